crack_scheduler: RTL and testbench
==================================

CRACK_SCHEDULER -- requirements
Module: crack_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of RC4 cracking cores served.
REQ-002 SHALL have parameter KEY_W, default 24, secret-key width.
REQ-003 SHALL have parameter KEY_LIMIT, default 24'h3FFFFF, highest key searched.
REQ-004 SHALL have parameter CHUNK_SIZE, default 4096, keys per grant; power of two.
REQ-005 SHALL have port clk input 1: sole clock, rising edge.
REQ-006 SHALL have port reset input 1: asynchronous, active-high.
REQ-007 SHALL have port start input 1: begin search; level sampled in IDLE only.
REQ-008 SHALL have port work_req input NUM_CORES: core i idle and requesting a chunk.
REQ-009 SHALL have port core_hit input NUM_CORES: one-cycle pulse, core i decoded valid plaintext.
REQ-010 SHALL have port core_hit_key input NUM_CORES*KEY_W: key of core i, slice [i*KEY_W +: KEY_W].
REQ-011 SHALL have port grant output NUM_CORES: one-hot, one-cycle pulse.
REQ-012 SHALL have port grant_base output KEY_W: first key of granted chunk, valid with grant.
REQ-013 SHALL have port grant_last output KEY_W: last key of granted chunk, valid with grant.
REQ-014 SHALL have port stop output 1: broadcast abort to all cores.
REQ-015 SHALL have ports busy, success, total_failure output 1 each: search status.
REQ-016 SHALL have ports secret_key output KEY_W and winner output $clog2(NUM_CORES): found key and finding core.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> FOUND or EXHAUSTED; FOUND/EXHAUSTED hold until reset or start.
REQ-018 SHALL, in IDLE with start=1, set next_base=0, outstanding=0, rr_ptr=0 and enter RUN next cycle; busy=1 throughout RUN.
REQ-019 SHALL, in RUN, grant at most one core per cycle, round-robin from rr_ptr among cores with work_req=1 and outstanding bit clear; rr_ptr becomes winner+1 mod NUM_CORES.
REQ-020 SHALL register grant: request sampled cycle N yields grant in cycle N+1; grant_base=next_base, grant_last=min(next_base+CHUNK_SIZE-1, KEY_LIMIT); next_base advances by CHUNK_SIZE.
REQ-021 SHALL set outstanding[i] on grant[i] and clear it when work_req[i] rises (core finished its chunk); a core with outstanding set is never granted.
REQ-022 SHALL issue no grant once next_base > KEY_LIMIT; next_base computed in KEY_W+1 bits so no wrap-around.
REQ-023 SHALL, on any core_hit in RUN, pick lowest-index hitting core, latch secret_key and winner, assert success and stop, enter FOUND; a grant due that same cycle is suppressed.
REQ-024 SHALL enter EXHAUSTED when next_base > KEY_LIMIT, outstanding==0 and no core_hit this cycle; assert total_failure and stop.
REQ-025 SHALL ignore core_hit outside RUN and ignore start while in RUN.
REQ-026 SHALL, on start in FOUND/EXHAUSTED, clear success, total_failure, stop and restart as REQ-018.

Reset
REQ-027 SHALL on reset drive state=IDLE; grant=0, grant_base=0, grant_last=0, stop=0, busy=0, success=0, total_failure=0, secret_key=0, winner=0; internal counters 0.
REQ-028 SHALL abandon any in-progress search on reset mid-RUN; no grant pulse in the cycle reset deasserts.

Configuration
REQ-029 SHALL, with macro CRACK_SCHED_PERF_EN defined, add output grants_issued (32 bits) counting grants since last start, and saturate at all-ones.
REQ-030 SHALL, without CRACK_SCHED_PERF_EN, have no grants_issued port or counter logic.

Structure
REQ-031 SHALL place state enum, default KEY_LIMIT and CHUNK_SIZE constants in shared package crack_pkg.
REQ-032 SHALL implement round-robin selection in sub-module rr_arbiter (req, ptr in; one-hot gnt, index out).

Verification
REQ-033 SHALL test: start, work_req=4'b1111 held -> grants to cores 0,1,2,3 on consecutive cycles, bases 0,4096,8192,12288.
REQ-034 SHALL test: core 2 core_hit with key 24'h00ABCD at cycle 50 -> next cycle success=1, stop=1, secret_key=24'h00ABCD, winner=2, no further grants.
REQ-035 SHALL test: cores 1 and 3 core_hit same cycle, keys 24'h000111/24'h000333 -> winner=1, secret_key=24'h000111.
REQ-036 SHALL test: KEY_LIMIT=24'h002FFF, CHUNK_SIZE=4096, no hits -> exactly 3 grants, last grant_last=24'h002FFF, total_failure=1 after all cores re-request.
REQ-037 SHALL test: reset asserted mid-RUN after 5 grants -> all outputs at REQ-027 values asynchronously; subsequent start grants base 0.
REQ-038 SHALL test: only core 0 requests, holds work_req high after grant -> no second grant until work_req drops and re-rises.

Source files
------------

// File: rtl/crack_pkg.sv
// Shared constants, state encoding and helpers for the RC4 key-space crack scheduler.
package crack_pkg;

    localparam int          DEF_NUM_CORES  = 4;
    localparam int          DEF_KEY_W      = 24;
    localparam logic [23:0] DEF_KEY_LIMIT  = 24'h3FFFFF;
    localparam int          DEF_CHUNK_SIZE = 4096;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_RUN       = 2'd1;
    localparam state_t ST_FOUND     = 2'd2;
    localparam state_t ST_EXHAUSTED = 2'd3;

    // Index width that stays legal for a single-core build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crack_scheduler_if.sv
// Scheduler <-> cracking-core bus: work requests and hits in, chunk grants and abort out.
interface crack_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 24
);
    logic [NUM_CORES-1:0]       work_req;
    logic [NUM_CORES-1:0]       core_hit;
    logic [NUM_CORES*KEY_W-1:0] core_hit_key;
    logic [NUM_CORES-1:0]       grant;
    logic [KEY_W-1:0]           grant_base;
    logic [KEY_W-1:0]           grant_last;
    logic                       stop;

    modport master (
        input  work_req, core_hit, core_hit_key,
        output grant, grant_base, grant_last, stop
    );

    modport slave (
        output work_req, core_hit, core_hit_key,
        input  grant, grant_base, grant_last, stop
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins; one-hot gnt plus its index.
module rr_arbiter
    import crack_pkg::*;
#(
    parameter int N     = DEF_NUM_CORES,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] index
);

    logic             found;
    logic [IDX_W-1:0] cand;
    int               sum;

    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        sum   = 0;
        for (int i = 0; i < N; i++) begin
            sum  = (int'(ptr) + i) % N;
            cand = IDX_W'(sum);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                index     = cand;
            end
        end
    end

endmodule

// File: rtl/crack_scheduler.sv
// Hands out KEY chunks to RC4 cores round-robin, one registered grant per cycle, until a hit or key-space exhaustion.
// Optional CRACK_SCHED_PERF_EN adds a saturating grants_issued counter cleared on each start.
module crack_scheduler
    import crack_pkg::*;
#(
    parameter int               NUM_CORES  = DEF_NUM_CORES,
    parameter int               KEY_W      = DEF_KEY_W,
    parameter logic [KEY_W-1:0] KEY_LIMIT  = DEF_KEY_LIMIT,
    parameter int               CHUNK_SIZE = DEF_CHUNK_SIZE,
    localparam int              IDX_W      = idx_width(NUM_CORES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    crack_scheduler_if.master   cores,
    output logic                busy,
    output logic                success,
    output logic                total_failure,
    output logic [KEY_W-1:0]    secret_key,
    output logic [IDX_W-1:0]    winner
`ifdef CRACK_SCHED_PERF_EN
    ,
    output logic [31:0]         grants_issued
`endif
);

    localparam logic [KEY_W:0] LIMIT_X = {1'b0, KEY_LIMIT};
    localparam logic [KEY_W:0] CHUNK_X = (KEY_W+1)'(CHUNK_SIZE);
    localparam logic [KEY_W:0] ONE_X   = (KEY_W+1)'(1);

    state_t               state;
    logic [KEY_W:0]       next_base;
    logic [NUM_CORES-1:0] outstanding;
    logic [NUM_CORES-1:0] work_req_q;
    logic [IDX_W-1:0]     rr_ptr;

    logic [NUM_CORES-1:0] req_rise;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic [IDX_W-1:0]     ptr_next;
    logic [KEY_W:0]       chunk_end;
    logic [KEY_W-1:0]     last_clip;
    logic                 any_hit;
    logic                 space_left;
    logic                 grant_now;
    logic                 restart;
    logic [IDX_W-1:0]     hit_idx;
    logic [KEY_W-1:0]     hit_key;

    // A rising work_req means the core finished its previous chunk.
    assign req_rise   = cores.work_req & ~work_req_q;
    assign eligible   = cores.work_req & ~outstanding;
    assign any_hit    = |cores.core_hit;
    // next_base carries an extra bit so stepping past KEY_LIMIT never wraps to 0.
    assign space_left = (next_base <= LIMIT_X);
    assign chunk_end  = next_base + CHUNK_X - ONE_X;
    assign last_clip  = (chunk_end > LIMIT_X) ? KEY_LIMIT : chunk_end[KEY_W-1:0];
    assign grant_now  = (state == ST_RUN) && !any_hit && space_left && (|arb_gnt);
    assign restart    = start && (state != ST_RUN);
    assign ptr_next   = (arb_idx == IDX_W'(NUM_CORES-1)) ? '0 : arb_idx + 1'b1;
    assign busy       = (state == ST_RUN);

    rr_arbiter #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .index (arb_idx)
    );

    // Lowest-index hitting core wins simultaneous hits.
    always_comb begin
        hit_idx = '0;
        hit_key = '0;
        for (int i = NUM_CORES-1; i >= 0; i--) begin
            if (cores.core_hit[i]) begin
                hit_idx = IDX_W'(i);
                hit_key = cores.core_hit_key[i*KEY_W +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            next_base        <= '0;
            outstanding      <= '0;
            work_req_q       <= '0;
            rr_ptr           <= '0;
            cores.grant      <= '0;
            cores.grant_base <= '0;
            cores.grant_last <= '0;
            cores.stop       <= 1'b0;
            success          <= 1'b0;
            total_failure    <= 1'b0;
            secret_key       <= '0;
            winner           <= '0;
        end else begin
            cores.grant <= '0;
            work_req_q  <= cores.work_req;
            if (restart) begin
                state         <= ST_RUN;
                next_base     <= '0;
                outstanding   <= '0;
                rr_ptr        <= '0;
                cores.stop    <= 1'b0;
                success       <= 1'b0;
                total_failure <= 1'b0;
            end else if (state == ST_RUN) begin
                outstanding <= (outstanding & ~req_rise) | (grant_now ? arb_gnt : '0);
                if (any_hit) begin
                    state      <= ST_FOUND;
                    success    <= 1'b1;
                    cores.stop <= 1'b1;
                    secret_key <= hit_key;
                    winner     <= hit_idx;
                end else if (!space_left && (outstanding == '0)) begin
                    state         <= ST_EXHAUSTED;
                    total_failure <= 1'b1;
                    cores.stop    <= 1'b1;
                end
                if (grant_now) begin
                    cores.grant      <= arb_gnt;
                    cores.grant_base <= next_base[KEY_W-1:0];
                    cores.grant_last <= last_clip;
                    next_base        <= next_base + CHUNK_X;
                    rr_ptr           <= ptr_next;
                end
            end
        end
    end

`ifdef CRACK_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grants_issued <= '0;
        end else if (restart) begin
            grants_issued <= '0;
        end else if (grant_now && (grants_issued != '1)) begin
            grants_issued <= grants_issued + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crack_scheduler.sv
// Scoreboarded bench: default-limit DUT for arbitration/hit/reset scenarios, small-limit DUT for exhaustion.
module tb_crack_scheduler;

    typedef struct {
        logic [3:0]  gnt;
        logic [23:0] base;
        logic [23:0] last;
    } exp_t;

    localparam logic [24:0] LIM_A = 25'h3FFFFF;
    localparam logic [24:0] LIM_B = 25'h002FFF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int grants_a = 0;
    int grants_b = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    crack_scheduler_if #(.NUM_CORES(4), .KEY_W(24)) if_a ();
    crack_scheduler_if #(.NUM_CORES(4), .KEY_W(24)) if_b ();

    logic        busy_a, success_a, tf_a, busy_b, success_b, tf_b;
    logic [23:0] key_a, key_b;
    logic [1:0]  win_a, win_b;
`ifdef CRACK_SCHED_PERF_EN
    logic [31:0] gi_a, gi_b;
`endif

    crack_scheduler dut_a (
        .clk           (clk),
        .reset         (reset),
        .start         (start_a),
        .cores         (if_a.master),
        .busy          (busy_a),
        .success       (success_a),
        .total_failure (tf_a),
        .secret_key    (key_a),
        .winner        (win_a)
`ifdef CRACK_SCHED_PERF_EN
        , .grants_issued (gi_a)
`endif
    );

    crack_scheduler #(.KEY_LIMIT(24'h002FFF), .CHUNK_SIZE(4096)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .start         (start_b),
        .cores         (if_b.master),
        .busy          (busy_b),
        .success       (success_b),
        .total_failure (tf_b),
        .secret_key    (key_b),
        .winner        (win_b)
`ifdef CRACK_SCHED_PERF_EN
        , .grants_issued (gi_b)
`endif
    );

    function automatic exp_t mk(input int core, input logic [24:0] base, input logic [24:0] limit);
        exp_t e;
        logic [24:0] end_k;
        end_k  = base + 25'd4095;
        e.gnt  = 4'b0001 << core;
        e.base = base[23:0];
        e.last = (end_k > limit) ? limit[23:0] : end_k[23:0];
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) if (!reset) cyc++;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset && if_a.grant != 4'b0) begin
            grants_a++;
            n_checks++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL grant_a_unexpected got grant=%b base=%h want none", if_a.grant, if_a.grant_base);
            end else begin
                e = exp_a.pop_front();
                if ({if_a.grant, if_a.grant_base, if_a.grant_last} !== {e.gnt, e.base, e.last}) begin
                    n_fail++;
                    $display("FAIL grant_a got %b/%h/%h want %b/%h/%h", if_a.grant, if_a.grant_base,
                             if_a.grant_last, e.gnt, e.base, e.last);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!reset && if_b.grant != 4'b0) begin
            grants_b++;
            n_checks++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL grant_b_unexpected got grant=%b base=%h want none", if_b.grant, if_b.grant_base);
            end else begin
                e = exp_b.pop_front();
                if ({if_b.grant, if_b.grant_base, if_b.grant_last} !== {e.gnt, e.base, e.last}) begin
                    n_fail++;
                    $display("FAIL grant_b got %b/%h/%h want %b/%h/%h", if_b.grant, if_b.grant_base,
                             if_b.grant_last, e.gnt, e.base, e.last);
                end
            end
        end
    end

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if ({if_a.grant, if_a.grant_base, if_a.grant_last} !== 52'd0) begin
            n_fail++;
            $display("FAIL reset_grant_bus got %b/%h/%h want 0", if_a.grant, if_a.grant_base, if_a.grant_last);
        end
        n_checks++;
        if ({if_a.stop, busy_a, success_a, tf_a} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_status got %b want 0000", {if_a.stop, busy_a, success_a, tf_a});
        end
        n_checks++;
        if ({key_a, win_a} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_key_winner got %h/%0d want 0/0", key_a, win_a);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++) exp_a.push_back(mk(k, 25'(k * 4096), LIM_A));
        start_a = 1'b1;
        if_a.work_req = 4'b1111;
        tick();
        start_a = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_busy got %b want 1", busy_a);
        end
        for (int i = 0; i < 10 && if_a.grant == 4'b0; i++) tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (if_a.grant !== (4'b0001 << k)) begin
                n_fail++;
                $display("FAIL rr_consecutive_%0d got %b want %b", k, if_a.grant, 4'b0001 << k);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (exp_a.size() != 0 || grants_a != 4) begin
            n_fail++;
            $display("FAIL rr_grant_count got %0d pending=%0d want 4 pending=0", grants_a, exp_a.size());
        end
    endtask

    task automatic test_hit();
        for (int i = 0; i < 200 && cyc < 48; i++) tick();
        // Re-arm core 0 so a grant would be due exactly on the hit cycle.
        if_a.work_req = 4'b1110;
        tick();
        if_a.work_req = 4'b1111;
        tick();
        if_a.core_hit = 4'b0100;
        if_a.core_hit_key = '0;
        if_a.core_hit_key[2*24 +: 24] = 24'h00ABCD;
        tick();
        if_a.core_hit = 4'b0000;
        n_checks++;
        if ({success_a, if_a.stop, busy_a} !== 3'b110) begin
            n_fail++;
            $display("FAIL hit_status got succ/stop/busy=%b want 110", {success_a, if_a.stop, busy_a});
        end
        n_checks++;
        if (key_a !== 24'h00ABCD || win_a !== 2'd2) begin
            n_fail++;
            $display("FAIL hit_key got %h/%0d want 00abcd/2", key_a, win_a);
        end
        if_a.work_req = 4'b0000;
        tick();
        if_a.work_req = 4'b1111;
        if_a.core_hit = 4'b0001;
        if_a.core_hit_key[0 +: 24] = 24'h000777;
        tick();
        if_a.core_hit = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (grants_a != 4 || key_a !== 24'h00ABCD || win_a !== 2'd2) begin
            n_fail++;
            $display("FAIL hit_after got grants=%0d key=%h win=%0d want 4/00abcd/2", grants_a, key_a, win_a);
        end
    endtask

    task automatic test_dual_hit();
        if_a.work_req = 4'b0000;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_checks++;
        if ({busy_a, success_a, if_a.stop} !== 3'b100) begin
            n_fail++;
            $display("FAIL restart_status got busy/succ/stop=%b want 100", {busy_a, success_a, if_a.stop});
        end
        if_a.core_hit = 4'b1010;
        if_a.core_hit_key = '0;
        if_a.core_hit_key[1*24 +: 24] = 24'h000111;
        if_a.core_hit_key[3*24 +: 24] = 24'h000333;
        tick();
        if_a.core_hit = 4'b0000;
        n_checks++;
        if (win_a !== 2'd1 || key_a !== 24'h000111 || success_a !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_hit got win=%0d key=%h succ=%b want 1/000111/1", win_a, key_a, success_a);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int k = 0; k < 4; k++) exp_a.push_back(mk(k, 25'(k * 4096), LIM_A));
        start_a = 1'b1;
        if_a.work_req = 4'b1111;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 12 && exp_a.size() != 0; i++) tick();
        if_a.work_req = 4'b1110;
        tick();
        exp_a.push_back(mk(0, 25'h4000, LIM_A));
        if_a.work_req = 4'b1111;
        for (int i = 0; i < 12 && exp_a.size() != 0; i++) tick();
        n_checks++;
        if (exp_a.size() != 0) begin
            n_fail++;
            $display("FAIL midrun_five_grants got pending=%0d want 0", exp_a.size());
        end
`ifdef CRACK_SCHED_PERF_EN
        n_checks++;
        if (gi_a !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_count got %0d want 5", gi_a);
        end
`endif
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({if_a.grant, if_a.grant_base, if_a.grant_last, if_a.stop, busy_a, success_a, tf_a} !== 56'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs got %b/%h/%h/%b want all 0", if_a.grant, if_a.grant_base,
                     if_a.grant_last, {if_a.stop, busy_a, success_a, tf_a});
        end
        n_checks++;
        if ({key_a, win_a} !== 26'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_key got %h/%0d want 0/0", key_a, win_a);
        end
        tick();
        tick();
        reset = 1'b0;
        exp_a.delete();
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got busy=%b want 0", busy_a);
        end
    endtask

    task automatic test_single_core();
        int g0;
        g0 = grants_a;
        exp_a.push_back(mk(0, 25'h0, LIM_A));
        if_a.work_req = 4'b0001;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (grants_a - g0 != 1 || exp_a.size() != 0) begin
            n_fail++;
            $display("FAIL single_hold got grants=%0d pending=%0d want 1/0", grants_a - g0, exp_a.size());
        end
        if_a.work_req = 4'b0000;
        tick();
        exp_a.push_back(mk(0, 25'h1000, LIM_A));
        if_a.work_req = 4'b0001;
        for (int i = 0; i < 10 && exp_a.size() != 0; i++) tick();
        n_checks++;
        if (grants_a - g0 != 2 || exp_a.size() != 0) begin
            n_fail++;
            $display("FAIL single_rerise got grants=%0d pending=%0d want 2/0", grants_a - g0, exp_a.size());
        end
    endtask

    task automatic test_exhaust();
        for (int k = 0; k < 3; k++) exp_b.push_back(mk(k, 25'(k * 4096), LIM_B));
        if_b.work_req = 4'b1111;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (grants_b != 3 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL exhaust_grants got %0d pending=%0d want 3/0", grants_b, exp_b.size());
        end
        n_checks++;
        if ({tf_b, busy_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL exhaust_waiting got tf/busy=%b want 01", {tf_b, busy_b});
        end
        if_b.work_req = 4'b0000;
        tick();
        if_b.work_req = 4'b1111;
        for (int i = 0; i < 10 && tf_b !== 1'b1; i++) tick();
        n_checks++;
        if ({tf_b, if_b.stop, busy_b, success_b} !== 4'b1100 || grants_b != 3) begin
            n_fail++;
            $display("FAIL exhaust_final got tf/stop/busy/succ=%b grants=%0d want 1100/3",
                     {tf_b, if_b.stop, busy_b, success_b}, grants_b);
        end
    endtask

    initial begin
        if_a.work_req = '0;
        if_a.core_hit = '0;
        if_a.core_hit_key = '0;
        if_b.work_req = '0;
        if_b.core_hit = '0;
        if_b.core_hit_key = '0;
        test_reset();
        test_round_robin();
        test_hit();
        test_dual_hit();
        test_reset_mid_run();
        test_single_core();
        test_exhaust();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
